imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 110 +++++++++++
 tb/tb_imem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one instruction-memory port between a loader and fetch.
// Define IMEM_ARB_RR_EN for round-robin tie-break; default is loader priority.
module imem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_req,
  input  logic [3:0]  ld_addr,
  input  logic [25:0] ld_data,
  output logic        ld_ack,
  input  logic        f_req,
  input  logic [3:0]  f_addr,
  output logic        f_valid,
  output logic [25:0] f_instr,
  output logic [3:0]  mem_addr,
  output logic        mem_we,
  output logic [25:0] mem_wdata,
  input  logic [25:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_CAPT  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  addr_q, addr_d;
  logic [25:0] wdata_q, wdata_d;
  logic [25:0] instr_q, instr_d;
  logic        idle;
  logic        grant_wr;
  logic        grant_rd;

  assign idle = (state_q == S_IDLE);

`ifdef IMEM_ARB_RR_EN
  // fpri_q set: fetch wins the next tie
  logic fpri_q, fpri_d;

  always_comb begin
    grant_rd = idle & f_req & (~ld_req | fpri_q);
    grant_wr = idle & ld_req & ~grant_rd;
    fpri_d   = fpri_q;
    if (grant_wr)
      fpri_d = 1'b1;
    else if (grant_rd)
      fpri_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      fpri_q <= 1'b0;
    else
      fpri_q <= fpri_d;
  end
`else
  assign grant_wr = idle & ld_req;
  assign grant_rd = idle & f_req & ~ld_req;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    instr_d = instr_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_wr) begin
          state_d = S_WRITE;
          addr_d  = ld_addr;
          wdata_d = ld_data;
        end else if (grant_rd) begin
          state_d = S_READ;
          addr_d  = f_addr;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_READ:  state_d = S_CAPT;
      S_CAPT: begin
        state_d = S_IDLE;
        instr_d = mem_rdata;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
    end
  end

  assign mem_we    = (state_q == S_WRITE);
  assign ld_ack    = (state_q == S_WRITE);
  assign f_valid   = (state_q == S_CAPT);
  assign busy      = ~idle;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  // read data is live during CAPTURE and held in instr_q afterwards
  assign f_instr   = f_valid ? mem_rdata : instr_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: random loader/fetch traffic against a queue scoreboard.
// Arbitration order and memory contents come from a behavioural model.
module tb_imem_arbiter;

`ifdef IMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req;
  logic [3:0]  ld_addr;
  logic [25:0] ld_data;
  logic        ld_ack;
  logic        f_req;
  logic [3:0]  f_addr;
  logic        f_valid;
  logic [25:0] f_instr;
  logic [3:0]  mem_addr;
  logic        mem_we;
  logic [25:0] mem_wdata;
  logic [25:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        is_rd;
    logic [3:0]  addr;
    logic [25:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [25:0] ref_mem[16];
  bit          last_wr;
  logic [25:0] last_rd;
  logic [25:0] mem[16];

  logic [3:0]  wa[8];
  logic [25:0] wd[8];
  logic [3:0]  ra[8];

  imem_arbiter dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .f_req(f_req), .f_addr(f_addr), .f_valid(f_valid), .f_instr(f_instr),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // synchronous single-port RAM, one-cycle read latency
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      last_rd = '0;
      chk("rst_quiet", {29'd0, ld_ack, f_valid, mem_we}, 32'd0);
    end else begin
      chk("we_vs_ack", {31'd0, mem_we}, {31'd0, ld_ack});
      if (ld_ack || f_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out ld_ack=%0b f_valid=%0b none queued",
                   ld_ack, f_valid);
        end else begin
          e = exp_q.pop_front();
          chk("kind", {31'd0, f_valid}, {31'd0, e.is_rd});
          if (e.is_rd) begin
            chk("f_instr", {6'd0, f_instr}, {6'd0, e.data});
            last_rd = e.data;
          end else begin
            chk("mem_addr", {28'd0, mem_addr}, {28'd0, e.addr});
            chk("mem_wdata", {6'd0, mem_wdata}, {6'd0, e.data});
          end
        end
      end else begin
        chk("f_instr_hold", {6'd0, f_instr}, {6'd0, last_rd});
      end
    end
  end

  // Model: grants in spec order; ties go to loader, or alternate under RR.
  task automatic model(int nw, int nr);
    int wi = 0;
    int ri = 0;
    bit wwin;
    while (wi < nw || ri < nr) begin
      if (wi < nw && ri < nr) wwin = RR ? !last_wr : 1'b1;
      else                    wwin = (wi < nw);
      if (wwin) begin
        exp_q.push_back('{1'b0, wa[wi], wd[wi]});
        ref_mem[wa[wi]] = wd[wi];
        last_wr = 1'b1;
        wi++;
      end else begin
        exp_q.push_back('{1'b1, ra[ri], ref_mem[ra[ri]]});
        last_wr = 1'b0;
        ri++;
      end
    end
  endtask

  task automatic run(int nw, int nr);
    int wi = 0;
    int ri = 0;
    int cyc = 0;
    model(nw, nr);
    @(posedge clk); #1;
    ld_req = (nw > 0); ld_addr = wa[0]; ld_data = wd[0];
    f_req  = (nr > 0); f_addr  = ra[0];
    while ((wi < nw || ri < nr) && cyc < 20 * (nw + nr) + 10) begin
      @(posedge clk); #1;
      cyc++;
      if (ld_req && ld_ack) begin
        if (nw == 1 && nr == 0) chk("ld_latency", cyc, 1);
        wi++;
        ld_req = (wi < nw);
        if (wi < nw) begin ld_addr = wa[wi]; ld_data = wd[wi]; end
      end
      if (f_req && f_valid) begin
        if (nr == 1 && nw == 0) chk("f_latency", cyc, 2);
        ri++;
        f_req = (ri < nr);
        if (ri < nr) f_addr = ra[ri];
      end
    end
    chk("stream_done", wi + ri, nw + nr);
    ld_req = 1'b0;
    f_req  = 1'b0;
  endtask

  function automatic logic [3:0] raddr();
    int r = $urandom_range(0, 5);
    if (r == 0) return 4'h0;
    if (r == 1) return 4'hF;
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic wait_valid(string nm, int want);
    int cyc = 0;
    bit seen = 0;
    while (!seen && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      seen = f_valid;
    end
    chk(nm, cyc, want);
    f_req = 1'b0;
  endtask

  initial begin
    reset = 1'b0; ld_req = 1'b0; f_req = 1'b0;
    ld_addr = '0; ld_data = '0; f_addr = '0;
    last_wr = 1'b0; last_rd = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ld_ack", {31'd0, ld_ack}, 32'd0);
    chk("rst_f_valid", {31'd0, f_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {6'd0, mem_wdata}, 32'd0);
    chk("rst_f_instr", {6'd0, f_instr}, 32'd0);
    reset = 1'b1;

    wa[0] = 4'd3; wd[0] = 26'h5555; run(1, 0);
    ra[0] = 4'd3; run(0, 1);
    wa[0] = 4'd9; wd[0] = 26'h2AAAA; run(1, 0);
    ra[0] = 4'd9; run(0, 1);
    ra[0] = 4'd3; run(0, 1);

    for (int i = 0; i < 16; i++) begin
      wa[0] = 4'(i); wd[0] = 26'($urandom()); run(1, 0);
    end

    for (int i = 0; i < 4; i++) begin
      wa[i] = raddr(); wd[i] = 26'($urandom()); ra[i] = raddr();
    end
    run(4, 4);

    // reset while READ is in flight; held f_req is served afresh
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 4'd9;
    @(posedge clk); #1;
    chk("busy_in_read", {31'd0, busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rst_busy_now", {31'd0, busy}, 32'd0);
    chk("rst_fv_now", {31'd0, f_valid}, 32'd0);
    last_wr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    ra[0] = 4'd9;
    model(0, 1);
    wait_valid("f_lat_post_rst", 2);

    // reset while WRITE is in flight; memory must keep its old word
    @(posedge clk); #1;
    ld_req = 1'b1; ld_addr = 4'd5; ld_data = ~ref_mem[5];
    @(posedge clk); #1;
    chk("we_in_write", {31'd0, mem_we}, 32'd1);
    #1 reset = 1'b0; ld_req = 1'b0;
    #1;
    chk("rst_we_now", {31'd0, mem_we}, 32'd0);
    chk("rst_ack_now", {31'd0, ld_ack}, 32'd0);
    last_wr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    ra[0] = 4'd5; run(0, 1);

    for (int it = 0; it < 30; it++) begin
      int nw = $urandom_range(0, 3);
      int nr = $urandom_range(0, 3);
      if (nw + nr == 0) nw = 1;
      for (int i = 0; i < 4; i++) begin
        wa[i] = raddr(); wd[i] = 26'($urandom()); ra[i] = raddr();
      end
      run(nw, nr);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
